// File: rtl/quantum_scheduler_pkg.sv
// Shared types and constants for the round-robin time-slice scheduler.
package quantum_scheduler_pkg;

    localparam int PC_W                    = 32;
    localparam int DEFAULT_QUANTUM_RESET   = 64;

    // Controller states; RUN is the only state in which the core may advance.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        SAVE   = 3'd2,
        SELECT = 3'd3,
        LOAD   = 3'd4
    } state_t;

endpackage

// File: rtl/quantum_scheduler_rr_pick.sv
// Combinational round-robin finder: first active slot after cur_prog,
// wrapping around, with cur_prog itself considered last.
module quantum_scheduler_rr_pick #(
    parameter int NUM_PROGS = 4,
    localparam int ID_W     = $clog2(NUM_PROGS)
) (
    input  logic [NUM_PROGS-1:0] active,
    input  logic [ID_W-1:0]      cur_prog,
    output logic [ID_W-1:0]      next_id,
    output logic                 found
);

    logic [ID_W-1:0] idx;

    // Scan cur_prog+1 .. cur_prog+NUM_PROGS; the modulo wrap comes free
    // from the power-of-two slot count.
    always_comb begin
        next_id = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_PROGS; i++) begin
            idx = cur_prog + ID_W'(i);
            if (!found && active[idx]) begin
                found   = 1'b1;
                next_id = idx;
            end
        end
    end

endmodule

// File: rtl/quantum_scheduler.sv
// Round-robin time-slice scheduler: keeps a saved-PC table per program slot,
// preempts the running slot on quantum expiry or program end, and drives
// the PC load for the next active slot.
//
// Handshake: none of the inputs are flow-controlled. instr_done,
// end_program, start_prog and def_quantum are single-cycle strobes sampled
// on every rising edge; load_pc is a one-cycle strobe that the PC must
// accept unconditionally, with pc_out valid only while load_pc is high.
module quantum_scheduler
    import quantum_scheduler_pkg::*;
#(
    parameter int NUM_PROGS       = 4,
    parameter int QUANTUM_W       = 16,
    parameter int DEFAULT_QUANTUM = DEFAULT_QUANTUM_RESET,
    localparam int ID_W           = $clog2(NUM_PROGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 instr_done,
    input  logic                 def_quantum,
    input  logic [QUANTUM_W-1:0] quantum_in,
    input  logic                 start_prog,
    input  logic [ID_W-1:0]      start_id,
    input  logic [PC_W-1:0]      start_pc,
    input  logic                 end_program,
    input  logic [PC_W-1:0]      pc_in,
    output logic                 stall,
    output logic                 load_pc,
    output logic [PC_W-1:0]      pc_out,
    output logic [ID_W-1:0]      cur_prog,
    output logic                 running,
    output state_t               state_dbg
);

    state_t                state;
    logic [NUM_PROGS-1:0]  active;
    logic [PC_W-1:0]       pc_tab [NUM_PROGS];
    logic [QUANTUM_W-1:0]  quantum_reg;
    logic [QUANTUM_W-1:0]  count;
    logic [ID_W-1:0]       next_id;
    logic [ID_W-1:0]       pick_id;
    logic                  pick_found;

    quantum_scheduler_rr_pick #(
        .NUM_PROGS (NUM_PROGS)
    ) u_rr_pick (
        .active   (active),
        .cur_prog (cur_prog),
        .next_id  (pick_id),
        .found    (pick_found)
    );

    assign stall     = (state != RUN);
    assign running   = (state == RUN);
    assign state_dbg = state;

    // Context table: a start_prog write overrides a SAVE write to the same slot.
    // Contents are don't-care after reset, so the table carries no reset.
    always_ff @(posedge clock) begin
        if (start_prog) begin
            pc_tab[start_id] <= start_pc;
        end else if (state == SAVE) begin
            pc_tab[cur_prog] <= pc_in;
        end
    end

    // Scheduler FSM with registered load strobe, PC, slot and quantum state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cur_prog    <= '0;
            next_id     <= '0;
            active      <= '0;
            count       <= '0;
            quantum_reg <= QUANTUM_W'(DEFAULT_QUANTUM);
            load_pc     <= 1'b0;
            pc_out      <= '0;
        end else begin
            load_pc <= 1'b0;

            // A zero quantum would never expire, so it is rejected outright.
            if (def_quantum && (quantum_in != '0)) begin
                quantum_reg <= quantum_in;
            end

            case (state)
                IDLE: begin
                    // start_prog is looked at directly so a fresh start
                    // reaches SELECT one cycle later.
                    if ((|active) || start_prog) begin
                        state <= SELECT;
                    end
                end
                RUN: begin
                    if (end_program) begin
                        active[cur_prog] <= 1'b0;
                        state            <= SELECT;
                    end else if (instr_done) begin
                        count <= count - QUANTUM_W'(1);
                        if (count == QUANTUM_W'(1)) begin
                            state <= SAVE;
                        end
                    end
                end
                SAVE: begin
                    state <= SELECT;
                end
                SELECT: begin
                    if (pick_found) begin
                        next_id <= pick_id;
                        load_pc <= 1'b1;
                        // Forward a start_pc landing on the chosen slot this cycle.
                        if (start_prog && (start_id == pick_id)) begin
                            pc_out <= start_pc;
                        end else begin
                            pc_out <= pc_tab[pick_id];
                        end
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    cur_prog <= next_id;
                    count    <= quantum_reg;
                    state    <= RUN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Placed last so activation wins over an end_program clear.
            if (start_prog) begin
                active[start_id] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed bench for quantum_scheduler: reset, single start, round robin,
// end_program paths, quantum reprogramming and corner collisions.
module tb_quantum_scheduler;
    import quantum_scheduler_pkg::*;

    localparam int NUM_PROGS = 4;
    localparam int QUANTUM_W = 16;
    localparam int ID_W      = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 instr_done = 1'b0;
    logic                 def_quantum = 1'b0;
    logic [QUANTUM_W-1:0] quantum_in = '0;
    logic                 start_prog = 1'b0;
    logic [ID_W-1:0]      start_id = '0;
    logic [31:0]          start_pc = '0;
    logic                 end_program = 1'b0;
    logic [31:0]          pc_in = '0;
    logic                 stall;
    logic                 load_pc;
    logic [31:0]          pc_out;
    logic [ID_W-1:0]      cur_prog;
    logic                 running;
    state_t               state_dbg;

    int tests  = 0;
    int failed = 0;

    quantum_scheduler #(
        .NUM_PROGS       (NUM_PROGS),
        .QUANTUM_W       (QUANTUM_W),
        .DEFAULT_QUANTUM (64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_done  (instr_done),
        .def_quantum (def_quantum),
        .quantum_in  (quantum_in),
        .start_prog  (start_prog),
        .start_id    (start_id),
        .start_pc    (start_pc),
        .end_program (end_program),
        .pc_in       (pc_in),
        .stall       (stall),
        .load_pc     (load_pc),
        .pc_out      (pc_out),
        .cur_prog    (cur_prog),
        .running     (running),
        .state_dbg   (state_dbg)
    );

    // Clock generation
    always #5 clock = ~clock;

    // Advance one edge; observe 1 time unit later, well away from the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic start(input logic [ID_W-1:0] id, input logic [31:0] pc);
        start_prog = 1'b1;
        start_id   = id;
        start_pc   = pc;
        step();
        start_prog = 1'b0;
    endtask

    task automatic pulse_instr(input int n);
        for (int i = 0; i < n; i++) begin
            instr_done = 1'b1;
            step();
        end
        instr_done = 1'b0;
    endtask

    // Bounded wait for a load_pc strobe; returns edges stepped.
    task automatic wait_load(input int max, output int cyc);
        cyc = 0;
        while (load_pc !== 1'b1 && cyc < max) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (stall !== 1'b1) begin failed++; $display("FAIL reset_stall: got %0b want 1", stall); end
        tests++; if (load_pc !== 1'b0) begin failed++; $display("FAIL reset_load_pc: got %0b want 0", load_pc); end
        tests++; if (pc_out !== 32'h0) begin failed++; $display("FAIL reset_pc_out: got %0h want 0", pc_out); end
        tests++; if (running !== 1'b0) begin failed++; $display("FAIL reset_running: got %0b want 0", running); end
        tests++; if (cur_prog !== 2'd0) begin failed++; $display("FAIL reset_cur_prog: got %0d want 0", cur_prog); end
        tests++; if (state_dbg !== IDLE) begin failed++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    endtask

    task automatic test_start_single();
        do_reset();
        def_quantum = 1'b1;
        quantum_in  = 16'd4;
        start_prog  = 1'b1;
        start_id    = 2'd0;
        start_pc    = 32'h10;
        step();
        def_quantum = 1'b0;
        start_prog  = 1'b0;
        tests++; if (state_dbg !== SELECT) begin failed++; $display("FAIL start_t1_select: got %0d want SELECT", state_dbg); end
        tests++; if (load_pc !== 1'b0) begin failed++; $display("FAIL start_t1_no_load: got %0b want 0", load_pc); end
        step();
        tests++; if (load_pc !== 1'b1) begin failed++; $display("FAIL start_t2_load_pc: got %0b want 1", load_pc); end
        tests++; if (pc_out !== 32'h10) begin failed++; $display("FAIL start_t2_pc_out: got %0h want 10", pc_out); end
        step();
        tests++; if (running !== 1'b1) begin failed++; $display("FAIL start_t3_running: got %0b want 1", running); end
        tests++; if (stall !== 1'b0) begin failed++; $display("FAIL start_t3_stall: got %0b want 0", stall); end
        tests++; if (load_pc !== 1'b0) begin failed++; $display("FAIL start_t3_load_drop: got %0b want 0", load_pc); end
        tests++; if (cur_prog !== 2'd0) begin failed++; $display("FAIL start_t3_cur_prog: got %0d want 0", cur_prog); end
        // Quantum of 4: still running after 3, expires on the 4th.
        pc_in = 32'h20;
        pulse_instr(3);
        tests++; if (running !== 1'b1) begin failed++; $display("FAIL start_q4_after3: got %0b want 1", running); end
        pulse_instr(1);
        tests++; if (state_dbg !== SAVE) begin failed++; $display("FAIL start_q4_save: got %0d want SAVE", state_dbg); end
    endtask

    task automatic test_round_robin();
        int cyc;
        do_reset();
        def_quantum = 1'b1;
        quantum_in  = 16'd3;
        start(2'd0, 32'h10);
        def_quantum = 1'b0;
        start(2'd2, 32'h40);
        tests++; if (pc_out !== 32'h10) begin failed++; $display("FAIL rr_first_pc: got %0h want 10", pc_out); end
        step();
        pc_in = 32'h1C;
        pulse_instr(3);
        tests++; if (state_dbg !== SAVE) begin failed++; $display("FAIL rr_expiry_save: got %0d want SAVE", state_dbg); end
        tests++; if (stall !== 1'b1) begin failed++; $display("FAIL rr_save_stall: got %0b want 1", stall); end
        step();
        tests++; if (stall !== 1'b1 || state_dbg !== SELECT) begin failed++; $display("FAIL rr_select_stall: got state %0d stall %0b want SELECT/1", state_dbg, stall); end
        step();
        tests++; if (load_pc !== 1'b1 || pc_out !== 32'h40) begin failed++; $display("FAIL rr_load_slot2: got load %0b pc %0h want 1/40", load_pc, pc_out); end
        tests++; if (stall !== 1'b1) begin failed++; $display("FAIL rr_load_stall: got %0b want 1", stall); end
        step();
        tests++; if (cur_prog !== 2'd2 || running !== 1'b1) begin failed++; $display("FAIL rr_run_slot2: got cur %0d run %0b want 2/1", cur_prog, running); end
        pc_in = 32'h24;
        pulse_instr(3);
        wait_load(10, cyc);
        tests++; if (load_pc !== 1'b1 || cyc != 2) begin failed++; $display("FAIL rr_reload_timing: got load %0b after %0d want 1 after 2", load_pc, cyc); end
        tests++; if (pc_out !== 32'h1C) begin failed++; $display("FAIL rr_reload_slot0_pc: got %0h want 1c", pc_out); end
        step();
        tests++; if (cur_prog !== 2'd0) begin failed++; $display("FAIL rr_reload_slot0_cur: got %0d want 0", cur_prog); end
    endtask

    // Continues from test_round_robin: slot 0 running, slot 2 saved at 0x24.
    task automatic test_end_program();
        int cyc;
        pc_in = 32'h2C;
        pulse_instr(3);
        wait_load(10, cyc);
        tests++; if (load_pc !== 1'b1 || pc_out !== 32'h24) begin failed++; $display("FAIL end_setup_slot2: got load %0b pc %0h want 1/24", load_pc, pc_out); end
        step();
        tests++; if (cur_prog !== 2'd2) begin failed++; $display("FAIL end_setup_cur: got %0d want 2", cur_prog); end
        end_program = 1'b1;
        step();
        end_program = 1'b0;
        tests++; if (state_dbg !== SELECT || stall !== 1'b1) begin failed++; $display("FAIL end_no_save: got state %0d stall %0b want SELECT/1", state_dbg, stall); end
        step();
        tests++; if (load_pc !== 1'b1 || pc_out !== 32'h2C || stall !== 1'b1) begin failed++; $display("FAIL end_load_slot0: got load %0b pc %0h stall %0b want 1/2c/1", load_pc, pc_out, stall); end
        step();
        tests++; if (running !== 1'b1 || cur_prog !== 2'd0) begin failed++; $display("FAIL end_run_slot0: got run %0b cur %0d want 1/0", running, cur_prog); end
        // Slot 2 is now inactive, so slot 0 reloads itself on expiry.
        pc_in = 32'h30;
        pulse_instr(3);
        wait_load(10, cyc);
        tests++; if (load_pc !== 1'b1 || pc_out !== 32'h30) begin failed++; $display("FAIL end_self_reload: got load %0b pc %0h want 1/30", load_pc, pc_out); end
        step();
        tests++; if (cur_prog !== 2'd0) begin failed++; $display("FAIL end_self_cur: got %0d want 0", cur_prog); end
    endtask

    // Continues: slot 0 is the only active program.
    task automatic test_last_end();
        end_program = 1'b1;
        step();
        end_program = 1'b0;
        tests++; if (state_dbg !== SELECT) begin failed++; $display("FAIL last_select: got %0d want SELECT", state_dbg); end
        step();
        tests++; if (state_dbg !== IDLE || stall !== 1'b1 || running !== 1'b0 || load_pc !== 1'b0) begin failed++; $display("FAIL last_idle: got state %0d stall %0b run %0b load %0b want IDLE/1/0/0", state_dbg, stall, running, load_pc); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (state_dbg !== IDLE || load_pc !== 1'b0) begin failed++; $display("FAIL last_stay_idle: got state %0d load %0b want IDLE/0", state_dbg, load_pc); end
        end
    endtask

    task automatic test_quantum();
        do_reset();
        def_quantum = 1'b1;
        quantum_in  = 16'd5;
        start(2'd0, 32'h100);
        def_quantum = 1'b0;
        step();
        step();
        instr_done  = 1'b1;
        def_quantum = 1'b1;
        quantum_in  = 16'd2;
        step();
        instr_done  = 1'b0;
        def_quantum = 1'b0;
        pulse_instr(3);
        tests++; if (running !== 1'b1) begin failed++; $display("FAIL quantum_cur_slice_4: got %0b want 1", running); end
        pulse_instr(1);
        tests++; if (state_dbg !== SAVE) begin failed++; $display("FAIL quantum_cur_slice_5: got %0d want SAVE", state_dbg); end
        // Zero quantum offered during SAVE must be ignored.
        def_quantum = 1'b1;
        quantum_in  = 16'd0;
        step();
        def_quantum = 1'b0;
        step();
        step();
        pulse_instr(1);
        tests++; if (running !== 1'b1) begin failed++; $display("FAIL quantum_next_slice_1: got %0b want 1", running); end
        pulse_instr(1);
        tests++; if (state_dbg !== SAVE) begin failed++; $display("FAIL quantum_next_slice_2: got %0d want SAVE", state_dbg); end
    endtask

    task automatic test_collisions();
        int cyc;
        do_reset();
        def_quantum = 1'b1;
        quantum_in  = 16'd2;
        start(2'd0, 32'h10);
        def_quantum = 1'b0;
        start(2'd1, 32'h30);
        step();
        pulse_instr(1);
        instr_done  = 1'b1;
        end_program = 1'b1;
        step();
        instr_done  = 1'b0;
        end_program = 1'b0;
        tests++; if (state_dbg !== SELECT) begin failed++; $display("FAIL coll_end_beats_expiry: got %0d want SELECT", state_dbg); end
        step();
        tests++; if (load_pc !== 1'b1 || pc_out !== 32'h30) begin failed++; $display("FAIL coll_load_slot1: got load %0b pc %0h want 1/30", load_pc, pc_out); end
        step();
        tests++; if (cur_prog !== 2'd1) begin failed++; $display("FAIL coll_cur_slot1: got %0d want 1", cur_prog); end
        pc_in = 32'h60;
        pulse_instr(2);
        wait_load(10, cyc);
        tests++; if (load_pc !== 1'b1 || pc_out !== 32'h60) begin failed++; $display("FAIL coll_slot0_gone: got load %0b pc %0h want 1/60", load_pc, pc_out); end
        step();
        // Restart of the ending slot wins over its clear.
        end_program = 1'b1;
        start_prog  = 1'b1;
        start_id    = 2'd1;
        start_pc    = 32'h77;
        step();
        end_program = 1'b0;
        start_prog  = 1'b0;
        step();
        tests++; if (load_pc !== 1'b1 || pc_out !== 32'h77) begin failed++; $display("FAIL coll_restart_wins: got load %0b pc %0h want 1/77", load_pc, pc_out); end
        step();
        tests++; if (cur_prog !== 2'd1 || running !== 1'b1) begin failed++; $display("FAIL coll_restart_run: got cur %0d run %0b want 1/1", cur_prog, running); end
        // Reset while saving returns to IDLE with no active slots.
        pulse_instr(2);
        tests++; if (state_dbg !== SAVE) begin failed++; $display("FAIL coll_pre_reset_save: got %0d want SAVE", state_dbg); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (state_dbg !== IDLE || stall !== 1'b1) begin failed++; $display("FAIL coll_reset_idle: got state %0d stall %0b want IDLE/1", state_dbg, stall); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (state_dbg !== IDLE || load_pc !== 1'b0) begin failed++; $display("FAIL coll_reset_inactive: got state %0d load %0b want IDLE/0", state_dbg, load_pc); end
        end
    endtask

    initial begin
        test_reset();
        test_start_single();
        test_round_robin();
        test_end_program();
        test_last_end();
        test_quantum();
        test_collisions();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
